decoder_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 3-to-8 one-hot decoder between eight requesters. It picks one requester at a time, drives the decoder's three select inputs with the winner's index, and holds the grant until the requester releases or a hold limit expires. It inserts a one-cycle break-before-make gap between grants. It sits directly upstream of the decoder; each decoder output line is the per-channel select/enable.

---
 rtl/decoder_rr_arbiter_pkg.sv | 15 +
 rtl/decoder_rr_arbiter_if.sv | 24 ++
 rtl/decoder_rr_arbiter_rr_pick.sv | 30 +++
 rtl/decoder_rr_arbiter.sv | 93 +++++++++
 tb/tb_decoder_rr_arbiter.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared constants and FSM encoding for the decoder round-robin arbiter
// and the rotating-priority pick logic.
package decoder_arb_pkg;

  localparam int NUM_CH = 8;
  localparam int IDX_W  = 3;

  // 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
// The sel_* lines drive the 3-to-8 decoder inputs directly.
interface decoder_rr_arbiter_if;
  import decoder_arb_pkg::*;

  logic [NUM_CH-1:0] req;
  logic              grant_valid;
  logic [IDX_W-1:0]  grant_idx;
  logic              sel_1;
  logic              sel_2;
  logic              sel_3;
  logic              timeout;

  modport master (
    output req,
    input  grant_valid, grant_idx, sel_1, sel_2, sel_3, timeout
  );

  modport slave (
    input  req,
    output grant_valid, grant_idx, sel_1, sel_2, sel_3, timeout
  );

endinterface

// File: rtl/decoder_rr_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: returns the first requesting
// channel found when searching ptr, ptr+1, ... modulo NUM_CH.
module rr_pick
  import decoder_arb_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  pick,
  output logic              any
);

  logic [2*NUM_CH-1:0] req_dbl;
  logic [NUM_CH-1:0]   req_rot;

  // Rotating right by ptr puts channel ptr at bit 0, so the lowest set bit
  // of req_rot is the winner's offset from ptr.
  assign req_dbl = {req, req} >> ptr;
  assign req_rot = req_dbl[NUM_CH-1:0];
  assign any     = |req;

  always_comb begin
    // NOTE: pick gets a default before the search so every path assigns it
    // and no latch is inferred.
    pick = ptr;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_rot[i]) pick = ptr + IDX_W'(i);
    end
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 decoder between eight requesters,
// with bounded hold time and a one-cycle break-before-make gap.
module decoder_rr_arbiter
  import decoder_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  decoder_rr_arbiter_if.slave  bus
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] pick;
  logic             any;
  logic [7:0]       hold_cnt;
  logic [IDX_W-1:0] grant_idx_q;
  logic             grant_valid_q;
  logic             timeout_q;

  rr_pick u_rr_pick (
    .req  (bus.req),
    .ptr  (ptr),
    .pick (pick),
    .any  (any)
  );

  // NOTE: all state here is plain flops updated with non-blocking
  // assignments, so every register reads its pre-edge value and is reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      hold_cnt      <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          grant_valid_q <= 1'b0;
          if (any) begin
            grant_idx_q   <= pick;
            grant_valid_q <= 1'b1;
            hold_cnt      <= '0;
            state         <= ST_GRANT;
          end
        end

        ST_GRANT: begin
          // A release and a hold-limit expiry end the grant identically;
          // only an expiry with the request still high reports timeout.
          if (!bus.req[grant_idx_q] || hold_cnt == HOLD_LAST) begin
            grant_valid_q <= 1'b0;
            ptr           <= grant_idx_q + 1'b1;
            timeout_q     <= bus.req[grant_idx_q];
            state         <= ST_GAP;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end

        ST_GAP: begin
          if (any) begin
            grant_idx_q   <= pick;
            grant_valid_q <= 1'b1;
            hold_cnt      <= '0;
            state         <= ST_GRANT;
          end else begin
            state <= ST_IDLE;
          end
        end

        default: begin
          grant_valid_q <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.sel_1       = grant_idx_q[2];
  assign bus.sel_2       = grant_idx_q[1];
  assign bus.sel_3       = grant_idx_q[0];
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter with MAX_HOLD=4: priority rotation,
// hold limit, gap, no preemption and asynchronous reset.
module tb_decoder_rr_arbiter;

  logic sys_clk;
  logic sys_rst_n;
  int   checks;
  int   errors;

  decoder_rr_arbiter_if bus ();

  decoder_rr_arbiter #(.MAX_HOLD(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compares every arbiter output against one expected grant state.
  task automatic check_out(input string tag, input logic gv, input logic [2:0] idx,
                           input logic to);
    check({tag, ".grant_valid"}, 8'(bus.grant_valid), 8'(gv));
    check({tag, ".grant_idx"},   8'(bus.grant_idx),   8'(idx));
    check({tag, ".sel"},         8'({bus.sel_1, bus.sel_2, bus.sel_3}), 8'(idx));
    check({tag, ".timeout"},     8'(bus.timeout),     8'(to));
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    sys_rst_n = 1'b0;
    bus.req   = 8'h00;

    #12;
    check_out("reset", 1'b0, 3'd0, 1'b0);
    @(negedge sys_clk) sys_rst_n = 1'b1;
    step();
    check_out("idle_after_reset", 1'b0, 3'd0, 1'b0);

    // Single requester on channel 2.
    bus.req = 8'b0000_0100;
    step();
    check_out("t1_grant2", 1'b1, 3'd2, 1'b0);
    bus.req = 8'h00;
    step();
    check_out("t1_release", 1'b0, 3'd2, 1'b0);
    step();
    check_out("t1_gap_to_idle", 1'b0, 3'd2, 1'b0);
    step();
    check_out("t1_idle", 1'b0, 3'd2, 1'b0);

    // ptr=3 after channel 2: channel 7 beats channel 0.
    bus.req = 8'b1000_0001;
    step();
    check_out("ptr_ch7_first", 1'b1, 3'd7, 1'b0);
    bus.req = 8'b0000_0001;
    step();
    check_out("ptr_release7", 1'b0, 3'd7, 1'b0);
    step();
    check_out("ptr_then_ch0", 1'b1, 3'd0, 1'b0);
    bus.req = 8'h00;
    step();
    step();

    // Channel 5 holds while channel 1 waits; gap then channel 1.
    bus.req = 8'b0010_0000;
    step();
    check_out("pre_grant5", 1'b1, 3'd5, 1'b0);
    bus.req = 8'b0010_0010;
    step();
    check_out("pre_no_preempt", 1'b1, 3'd5, 1'b0);
    bus.req = 8'b0000_0010;
    step();
    check_out("pre_release5", 1'b0, 3'd5, 1'b0);
    step();
    check_out("pre_grant1", 1'b1, 3'd1, 1'b0);
    bus.req = 8'h00;
    step();
    step();

    // Full rotation under constant requests from ptr=0.
    @(negedge sys_clk) sys_rst_n = 1'b0;
    #1;
    check_out("rot_reset", 1'b0, 3'd0, 1'b0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    bus.req   = 8'hFF;
    for (int ch = 0; ch <= 8; ch++) begin
      step();
      check_out($sformatf("rot_grant%0d", ch), 1'b1, 3'(ch), 1'b0);
      for (int k = 1; k <= 3; k++) begin
        step();
        check_out($sformatf("rot_hold%0d_%0d", ch, k), 1'b1, 3'(ch), 1'b0);
      end
      if (ch < 8) begin
        step();
        check_out($sformatf("rot_timeout%0d", ch), 1'b0, 3'(ch), 1'b1);
      end
    end
    bus.req = 8'h00;
    step();
    check_out("rot_last_release", 1'b0, 3'd0, 1'b0);
    step();

    // Asynchronous reset in the middle of a channel 6 grant.
    bus.req = 8'b0100_0000;
    step();
    check_out("rst_grant6", 1'b1, 3'd6, 1'b0);
    step();
    check_out("rst_hold6", 1'b1, 3'd6, 1'b0);
    #2 sys_rst_n = 1'b0;
    #1;
    check_out("rst_async", 1'b0, 3'd0, 1'b0);
    @(negedge sys_clk) sys_rst_n = 1'b1;
    step();
    check_out("rst_regrant6", 1'b1, 3'd6, 1'b0);
    bus.req = 8'h00;
    step();
    step();

    // Lone channel 4 releases and stays low through the gap.
    bus.req = 8'b0001_0000;
    step();
    check_out("c4_grant", 1'b1, 3'd4, 1'b0);
    bus.req = 8'h00;
    step();
    check_out("c4_gap", 1'b0, 3'd4, 1'b0);
    step();
    check_out("c4_idle", 1'b0, 3'd4, 1'b0);
    step();
    check_out("c4_idle_stays", 1'b0, 3'd4, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
